// File: rtl/sound_i2s_tx.sv
// sound_i2s_tx: serial audio transmitter for the sound block's 20-bit
// left/right mixer outputs. Latches both channels once per frame and
// shifts them MSB-first on a 3-wire I2S link (bclk, lrck, sdata).
// Optional macro SOUND_I2S_LJ_EN selects left-justified format
// (no one-bit delay, lrck high for the left slot); the default build
// is standard I2S.
module sound_i2s_tx #(
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned SAMPLE_WIDTH = 20,
  parameter int unsigned SLOT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] left,
  input  logic [SAMPLE_WIDTH-1:0] right,
  output logic                    sample_strobe,
  output logic                    i2s_bclk,
  output logic                    i2s_lrck,
  output logic                    i2s_sdata
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(2 * SLOT_WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] SW_CNT   = CNT_W'(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] SW_M1    = CNT_W'(SAMPLE_WIDTH - 1);

`ifdef SOUND_I2S_LJ_EN
  localparam logic LRCK_LEFT = 1'b1;
`else
  localparam logic LRCK_LEFT = 1'b0;
`endif
  // Reset parks the link in the last bit of the right slot, so lrck
  // idles at the right-slot level for either format.
  localparam logic LRCK_RST = ~LRCK_LEFT;

  logic [DIV_W-1:0]        div_cnt_q,    div_cnt_d;
  logic                    bclk_q,       bclk_d;
  logic [CNT_W-1:0]        bit_cnt_q,    bit_cnt_d;
  logic                    lrck_q,       lrck_d;
  logic                    sdata_q,      sdata_d;
  logic                    strobe_q,     strobe_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q,  left_hold_d;
  logic [SAMPLE_WIDTH-1:0] right_hold_q, right_hold_d;

  logic                    bclk_toggle;
  logic                    bclk_fall;
  logic                    frame_start;
  logic                    right_slot;
  logic [CNT_W-1:0]        slot_k;
  logic [SAMPLE_WIDTH-1:0] slot_word;
  logic [SAMPLE_WIDTH-1:0] slot_shift;
  logic                    bit_val;

  // Clock divider: toggles bclk every CLK_DIV clk cycles.
  always_comb begin
    bclk_toggle = (div_cnt_q == DIV_LAST);
    div_cnt_d   = bclk_toggle ? '0 : div_cnt_q + 1'b1;
    bclk_d      = bclk_q ^ bclk_toggle;
    bclk_fall   = bclk_toggle & bclk_q;
  end

  // Bit counter advances on bclk falls; wrap to 0 starts a frame and
  // latches both channel samples.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    frame_start = 1'b0;
    if (bclk_fall) begin
      if (bit_cnt_q == CNT_LAST) begin
        bit_cnt_d   = '0;
        frame_start = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
    left_hold_d  = frame_start ? left  : left_hold_q;
    right_hold_d = frame_start ? right : right_hold_q;
    strobe_d     = frame_start;
  end

  // Serializer: lrck/sdata follow the new bit count on each bclk fall.
  // The *_hold_d values are used so that the bit emitted on the frame-start
  // fall already reflects the freshly latched sample.
  always_comb begin
    right_slot = (bit_cnt_d >= SLOT_CNT);
    slot_k     = right_slot ? (bit_cnt_d - SLOT_CNT) : bit_cnt_d;
    slot_word  = right_slot ? right_hold_d : left_hold_d;
    slot_shift = '0;
    bit_val    = 1'b0;
`ifdef SOUND_I2S_LJ_EN
    if (slot_k < SW_CNT) begin
      slot_shift = slot_word >> (SW_M1 - slot_k);
      bit_val    = slot_shift[0];
    end
`else
    if ((slot_k != '0) && (slot_k <= SW_CNT)) begin
      slot_shift = slot_word >> (SW_CNT - slot_k);
      bit_val    = slot_shift[0];
    end
`endif
    lrck_d  = lrck_q;
    sdata_d = sdata_q;
    if (bclk_fall) begin
      lrck_d  = right_slot ? ~LRCK_LEFT : LRCK_LEFT;
      sdata_d = bit_val;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      bit_cnt_q    <= CNT_LAST;
      lrck_q       <= LRCK_RST;
      sdata_q      <= 1'b0;
      strobe_q     <= 1'b0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      lrck_q       <= lrck_d;
      sdata_q      <= sdata_d;
      strobe_q     <= strobe_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
    end
  end

  assign sample_strobe = strobe_q;
  assign i2s_bclk      = bclk_q;
  assign i2s_lrck      = lrck_q;
  assign i2s_sdata     = sdata_q;

endmodule

// File: tb/tb_sound_i2s_tx.sv
// tb_sound_i2s_tx: directed bench for sound_i2s_tx with CLK_DIV=1 and
// CLK_DIV=3 instances; follows SOUND_I2S_LJ_EN for the expected format.
module tb_sound_i2s_tx;

`ifdef SOUND_I2S_LJ_EN
  localparam logic        RST_LRCK = 1'b0;
  localparam logic [63:0] WS_EXP   = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] DAT_MASK = 64'h000F_FFFF_000F_FFFF;
  localparam int          OFF      = 0;
`else
  localparam logic        RST_LRCK = 1'b1;
  localparam logic [63:0] WS_EXP   = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] DAT_MASK = 64'h001F_FFFE_001F_FFFE;
  localparam int          OFF      = 1;
`endif

  logic        clk;
  logic        rst;
  logic [19:0] left;
  logic [19:0] right;
  logic        strobe1, bclk1, lrck1, sdata1;
  logic        strobe3, bclk3, lrck3, sdata3;
  logic        use3;
  int          half;
  int          n_checks;
  int          n_fail;

  sound_i2s_tx #(.CLK_DIV(1), .SAMPLE_WIDTH(20), .SLOT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right),
    .sample_strobe(strobe1), .i2s_bclk(bclk1), .i2s_lrck(lrck1), .i2s_sdata(sdata1)
  );

  sound_i2s_tx #(.CLK_DIV(3), .SAMPLE_WIDTH(20), .SLOT_WIDTH(32)) dut3 (
    .clk(clk), .rst(rst), .left(left), .right(right),
    .sample_strobe(strobe3), .i2s_bclk(bclk3), .i2s_lrck(lrck3), .i2s_sdata(sdata3)
  );

  wire m_strobe = use3 ? strobe3 : strobe1;
  wire m_bclk   = use3 ? bclk3   : bclk1;
  wire m_lrck   = use3 ? lrck3   : lrck1;
  wire m_sdata  = use3 ? sdata3  : sdata1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame, bit b = value of sdata while bit_cnt == b.
  function automatic logic [63:0] exp_frame(input logic [19:0] l, input logic [19:0] r);
    logic [63:0] f;
    logic [19:0] h;
    logic [19:0] t;
    int          k;
    f = '0;
    for (int b = 0; b < 64; b++) begin
      k = b % 32;
      h = (b >= 32) ? r : l;
      t = '0;
`ifdef SOUND_I2S_LJ_EN
      if (k < 20) t = h >> (19 - k);
`else
      if (k >= 1 && k <= 20) t = h >> (20 - k);
`endif
      f = f | (64'(t[0]) << b);
    end
    return f;
  endfunction

  // Reassemble the 20-bit word of one slot from a captured frame.
  function automatic logic [19:0] get_word(input logic [63:0] dat, input int slot);
    logic [19:0] w;
    logic [63:0] t;
    w = '0;
    for (int i = 0; i < 20; i++) begin
      t = dat >> (slot * 32 + OFF + i);
      w = {w[18:0], t[0]};
    end
    return w;
  endfunction

  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    while (m_strobe !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Entered on the strobe cycle; returns on the next frame's strobe cycle.
  task automatic capture_frame(input int chg_bit, input logic [19:0] chg_left,
                               output logic [63:0] dat, output logic [63:0] ws);
    int   bad_bclk, bad_hold, bad_strobe;
    logic d0;
    bad_bclk = 0; bad_hold = 0; bad_strobe = 0;
    dat = '0; ws = '0;
    for (int b = 0; b < 64; b++) begin
      d0 = m_sdata;
      if (b == chg_bit) left = chg_left;
      for (int h = 0; h < 2 * half; h++) begin
        if (m_bclk !== (h >= half)) bad_bclk++;
        if (m_sdata !== d0) bad_hold++;
        if (m_strobe !== (b == 0 && h == 0)) bad_strobe++;
        if (h == half) begin
          dat = {m_sdata, dat[63:1]};
          ws  = {m_lrck, ws[63:1]};
        end
        @(negedge clk);
      end
    end
    check("bclk_shape", 64'(bad_bclk), 64'(0));
    check("sdata_only_on_fall", 64'(bad_hold), 64'(0));
    check("strobe_single", 64'(bad_strobe), 64'(0));
    check("strobe_period", 64'(m_strobe), 64'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bclk1"},   64'(bclk1),   64'(0));
    check({tag, "_lrck1"},   64'(lrck1),   64'(RST_LRCK));
    check({tag, "_sdata1"},  64'(sdata1),  64'(0));
    check({tag, "_strobe1"}, 64'(strobe1), 64'(0));
    check({tag, "_bclk3"},   64'(bclk3),   64'(0));
    check({tag, "_lrck3"},   64'(lrck3),   64'(RST_LRCK));
    check({tag, "_sdata3"},  64'(sdata3),  64'(0));
    check({tag, "_strobe3"}, 64'(strobe3), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] dat, ws;
    int          n;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; left = '0; right = '0; use3 = 1'b0; half = 1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // Frame 1: constant A5A5A / 5A5A5.
    left = 20'hA5A5A; right = 20'h5A5A5;
    rst = 1'b0;
    wait_strobe(20, n);
    check("first_strobe_latency", 64'(n), 64'(2));
    capture_frame(-1, 20'h0, dat, ws);
    check("f1_frame", dat, exp_frame(20'hA5A5A, 20'h5A5A5));
    check("f1_left", 64'(get_word(dat, 0)), 64'(20'hA5A5A));
    check("f1_right", 64'(get_word(dat, 1)), 64'(20'h5A5A5));
    check("f1_pad", dat & ~DAT_MASK, 64'h0);
    check("f1_lrck", ws, WS_EXP);

    // Frame 2: inputs cleared after the latch, frame still carries A5A5A.
    left = '0; right = '0;
    capture_frame(-1, 20'h0, dat, ws);
    check("f2_left", 64'(get_word(dat, 0)), 64'(20'hA5A5A));
    check("f2_frame", dat, exp_frame(20'hA5A5A, 20'h5A5A5));

    // Frame 3: left goes to all ones mid-left-slot, frame stays zero.
    capture_frame(10, 20'hFFFFF, dat, ws);
    check("f3_frame", dat, 64'h0);
    check("f3_lrck", ws, WS_EXP);

    // Frame 4: the ones appear now.
    left = 20'h80001; right = 20'hFFFFF;
    capture_frame(-1, 20'h0, dat, ws);
    check("f4_left", 64'(get_word(dat, 0)), 64'(20'hFFFFF));
    check("f4_right", 64'(get_word(dat, 1)), 64'(20'h0));
    check("f4_frame", dat, exp_frame(20'hFFFFF, 20'h0));

    // Frame 5: 80001 / FFFFF.
    capture_frame(-1, 20'h0, dat, ws);
    check("f5_left", 64'(get_word(dat, 0)), 64'(20'h80001));
    check("f5_right", 64'(get_word(dat, 1)), 64'(20'hFFFFF));
    check("f5_frame", dat, exp_frame(20'h80001, 20'hFFFFF));
    check("f5_pad", dat & ~DAT_MASK, 64'h0);

    // Reset pulse during the high phase of bit 40.
    repeat (81) @(negedge clk);
    check("pre_rst_bclk", 64'(bclk1), 64'(1));
    check("pre_rst_sdata", 64'(sdata1), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    wait_strobe(20, n);
    check("post_rst_strobe", 64'(n), 64'(2));
    capture_frame(-1, 20'h0, dat, ws);
    check("post_rst_frame", dat, exp_frame(20'h80001, 20'hFFFFF));

    // CLK_DIV=3 instance.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    use3 = 1'b1; half = 3;
    wait_strobe(40, n);
    check("div3_first_strobe", 64'(n), 64'(6));
    capture_frame(-1, 20'h0, dat, ws);
    check("div3_frame", dat, exp_frame(20'h80001, 20'hFFFFF));
    check("div3_lrck", ws, WS_EXP);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
